// File: rtl/pp_resize_pkg.sv
// Shared constants and state encoding for the resize coordinate sequencers.
// Positions are signed Q20.22; weights are the top fractional bits.
package pp_resize_pkg;
    localparam int IDX_W      = 16;
    localparam int WGT_W      = 8;
    localparam int FRAC_BITS  = 22;
    localparam int POS_W      = 42;
    localparam int IP_W       = POS_W - FRAC_BITS;
    localparam int SC_LATENCY = 6;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;
endpackage

// File: rtl/pp_resize_pos_decode.sv
// Splits a scaleCompute position into a clamped source index, its
// clamped +1 neighbour and a truncated bilinear weight.
import pp_resize_pkg::*;

module pp_resize_pos_decode (
    input  logic [POS_W-1:0] pos,
    input  logic [IDX_W-1:0] dim,
    output logic [IDX_W-1:0] index,
    output logic [IDX_W-1:0] index1,
    output logic [WGT_W-1:0] frac
);
    logic [IDX_W-1:0] dim_m1;
    logic [IP_W-1:0]  ip;

    // clamp at both ends; integer part compared at full width so no wrap
    always_comb begin
        dim_m1 = dim - IDX_W'(1);
        ip     = pos[POS_W-1:FRAC_BITS];
        index  = '0;
        frac   = '0;
        if (pos[POS_W-1]) begin
            index = '0;
        end else if (ip >= IP_W'(dim_m1)) begin
            index = dim_m1;
        end else begin
            index = ip[IDX_W-1:0];
            frac  = pos[FRAC_BITS-1 -: WGT_W];
        end
        index1 = (index == dim_m1) ? index : index + IDX_W'(1);
    end
endmodule

// File: rtl/pp_pipeline_accel_resize_coord_seq.sv
// Per-line coordinate sequencer: feeds indices into the ce-gated
// scaleCompute pipeline and streams decoded source coordinates.
import pp_resize_pkg::*;

module pp_pipeline_accel_resize_coord_seq (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             start,
    input  logic [IDX_W-1:0] out_dim,
    input  logic [IDX_W-1:0] in_dim,
    output logic             busy,
    output logic             done,
    output logic [31:0]      sc_currindex,
    output logic             sc_ce,
    input  logic [POS_W-1:0] sc_return,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [IDX_W-1:0] m_index,
    output logic [IDX_W-1:0] m_index1,
    output logic [WGT_W-1:0] m_frac,
    output logic             m_last
);
    state_t                  state;
    logic [IDX_W-1:0]        cnt;
    logic [IDX_W-1:0]        od_r;
    logic [IDX_W-1:0]        id_r;
    logic [SC_LATENCY-1:0]   vsr;
    logic [SC_LATENCY-1:0]   lsr;
    logic                    issue;
    logic                    issue_last;
    logic [IDX_W-1:0]        d_index;
    logic [IDX_W-1:0]        d_index1;
    logic [WGT_W-1:0]        d_frac;

    assign busy         = (state != IDLE);
    assign sc_ce        = busy & (~m_valid | m_ready);
    assign sc_currindex = {{(32-IDX_W){1'b0}}, cnt};
    assign issue        = (state == RUN);
    assign issue_last   = issue && (cnt == od_r - IDX_W'(1));

    pp_resize_pos_decode u_dec (
        .pos    (sc_return),
        .dim    (id_r),
        .index  (d_index),
        .index1 (d_index1),
        .frac   (d_frac)
    );

    // line FSM, issue tracking shift registers and output register
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            od_r     <= '0;
            id_r     <= '0;
            vsr      <= '0;
            lsr      <= '0;
            done     <= 1'b0;
            m_valid  <= 1'b0;
            m_index  <= '0;
            m_index1 <= '0;
            m_frac   <= '0;
            m_last   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        id_r <= in_dim;
                        od_r <= out_dim;
                        cnt  <= '0;
                        if (out_dim == '0) done  <= 1'b1;
                        else               state <= RUN;
                    end
                end
                RUN: begin
                    if (sc_ce) begin
                        cnt <= cnt + IDX_W'(1);
                        if (issue_last) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (m_valid && m_ready && m_last) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (sc_ce) begin
                vsr <= {vsr[SC_LATENCY-2:0], issue};
                lsr <= {lsr[SC_LATENCY-2:0], issue_last};
                if (vsr[SC_LATENCY-1]) begin
                    m_valid  <= 1'b1;
                    m_index  <= d_index;
                    m_index1 <= d_index1;
                    m_frac   <= d_frac;
                    m_last   <= lsr[SC_LATENCY-1];
                end else begin
                    m_valid  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_pp_pipeline_accel_resize_coord_seq.sv
// Scoreboard bench for the resize coordinate sequencer with a
// bit-exact ce-gated scaleCompute model.
module tb_pp_pipeline_accel_resize_coord_seq;
    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] out_dim = 16'd0;
    logic [15:0] in_dim = 16'd1;
    logic        busy;
    logic        done;
    logic [31:0] sc_currindex;
    logic        sc_ce;
    logic [41:0] sc_return;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [15:0] m_index;
    logic [15:0] m_index1;
    logic [7:0]  m_frac;
    logic        m_last;

    typedef struct {
        logic [15:0] idx;
        logic [15:0] idx1;
        logic [7:0]  fr;
        logic        last;
    } beat_t;

    beat_t       sb[$];
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    bit          chk_ce = 0;
    bit          rnd_ready = 0;
    bit          held = 0;
    logic [40:0] h_val;
    longint      inscale = 64'sd1 <<< 32;
    logic [41:0] scp[6];

    always #5 ap_clk = ~ap_clk;

    pp_pipeline_accel_resize_coord_seq dut (
        .ap_clk       (ap_clk),
        .ap_rst       (ap_rst),
        .start        (start),
        .out_dim      (out_dim),
        .in_dim       (in_dim),
        .busy         (busy),
        .done         (done),
        .sc_currindex (sc_currindex),
        .sc_ce        (sc_ce),
        .sc_return    (sc_return),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_index      (m_index),
        .m_index1     (m_index1),
        .m_frac       (m_frac),
        .m_last       (m_last)
    );

    function automatic logic [41:0] sc_f(input logic [31:0] i);
        longint t;
        t = ((longint'(i) <<< 22) | (64'sd1 <<< 21)) * inscale - (64'sd1 <<< 53);
        return 42'(t >>> 32);
    endfunction

    always @(posedge ap_clk) begin
        if (sc_ce) begin
            scp[0] <= sc_f(sc_currindex);
            for (int k = 1; k < 6; k++) scp[k] <= scp[k-1];
        end
    end
    assign sc_return = scp[5];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int idx, input int idx1, input int fr, input bit last);
        beat_t b;
        b.idx  = 16'(idx);
        b.idx1 = 16'(idx1);
        b.fr   = 8'(fr);
        b.last = last;
        sb.push_back(b);
    endtask

    // monitor: pops on every accepted beat, checks hold and ce rule
    always @(negedge ap_clk) begin
        if (ap_rst) begin
            held = 0;
        end else begin
            beat_t b;
            if (done) done_cnt++;
            if (chk_ce) chk("sc_ce_rule", sc_ce, busy & (~m_valid | m_ready));
            if (held && m_valid)
                chk("stall_hold", {m_index, m_index1, m_frac, m_last}, h_val);
            if (m_valid && m_ready) begin
                held = 0;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got index %0d expected none", m_index);
                end else begin
                    b = sb.pop_front();
                    chk("m_index", m_index, b.idx);
                    chk("m_index1", m_index1, b.idx1);
                    chk("m_frac", m_frac, b.fr);
                    chk("m_last", m_last, b.last);
                end
            end else if (m_valid) begin
                held  = 1;
                h_val = {m_index, m_index1, m_frac, m_last};
            end else begin
                held = 0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge ap_clk);
            #1 m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic start_line(input int id, input int od);
        @(posedge ap_clk);
        #1;
        in_dim  = 16'(id);
        out_dim = 16'(od);
        start   = 1'b1;
        @(posedge ap_clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_line(input int exp_done);
        int n = 0;
        while ((done_cnt < exp_done || sb.size() != 0) && n < 3000) begin
            @(posedge ap_clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL line_timeout: got %0d pending beats expected 0", sb.size());
        end
        repeat (3) @(posedge ap_clk);
        chk("done_count", done_cnt, exp_done);
        chk("busy_after_line", busy, 0);
    endtask

    task automatic push_down2;
        for (int i = 0; i < 8; i++) push(2 * i, 2 * i + 1, 128, i == 7);
    endtask

    initial begin
        int dc;
        repeat (3) @(posedge ap_clk);
        #1 ap_rst = 1'b0;
        @(negedge ap_clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sc_ce", sc_ce, 0);
        chk("rst_currindex", sc_currindex, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_out", {m_index, m_index1, m_frac, m_last}, 0);

        // downscale by 2
        inscale = 64'sd2 <<< 32;
        push_down2();
        start_line(16, 8);
        wait_line(1);

        // upscale by 2 with end clamping
        inscale = 64'sd1 <<< 31;
        push(0, 1, 0, 0);   push(0, 1, 64, 0);
        push(0, 1, 192, 0); push(1, 2, 64, 0);
        push(1, 2, 192, 0); push(2, 3, 64, 0);
        push(2, 3, 192, 0); push(3, 3, 0, 1);
        start_line(4, 8);
        wait_line(2);

        // random backpressure
        inscale = 64'sd2 <<< 32;
        rnd_ready = 1;
        chk_ce = 1;
        push_down2();
        start_line(16, 8);
        wait_line(3);
        rnd_ready = 0;
        chk_ce = 0;

        // empty line
        start_line(4, 0);
        @(negedge ap_clk);
        chk("empty_sc_ce", sc_ce, 0);
        chk("empty_m_valid", m_valid, 0);
        @(negedge ap_clk);
        chk("empty_done", done_cnt, 4);
        chk("empty_busy", busy, 0);

        // single pixel line
        inscale = 64'sd1 <<< 32;
        push(0, 0, 0, 1);
        start_line(1, 1);
        wait_line(5);

        // abort mid-line after three beats
        inscale = 64'sd2 <<< 32;
        push_down2();
        start_line(16, 8);
        for (int n = 0; n < 500 && sb.size() > 5; n++) @(posedge ap_clk);
        #1 ap_rst = 1'b1;
        @(posedge ap_clk);
        #1 ap_rst = 1'b0;
        sb.delete();
        dc = done_cnt;
        @(negedge ap_clk);
        chk("abort_busy", busy, 0);
        chk("abort_m_valid", m_valid, 0);
        repeat (10) @(posedge ap_clk);
        chk("abort_no_done", done_cnt, dc);
        push_down2();
        start_line(16, 8);
        wait_line(dc + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
